// File: rtl/f1_pkg.sv
// Shared types for the F1 start-light sequencer: FSM state encoding and
// maximal-length Fibonacci LFSR tap masks for widths 3..8.
package f1_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      HOLD   = 3'd2,
      TIMING = 3'd3,
      DONE   = 3'd4
   } f1_state_t;

   // Bit i set means stage i+1 feeds the XOR; values follow the usual
   // primitive-polynomial tables (e.g. width 8 uses stages 8,6,5,4).
   function automatic logic [7:0] lfsr_taps(input int width);
      case (width)
         3:       return 8'h06;
         4:       return 8'h0C;
         5:       return 8'h14;
         6:       return 8'h30;
         7:       return 8'h60;
         8:       return 8'hB8;
         default: return 8'h60;
      endcase
   endfunction

endpackage

// File: rtl/f1_lfsr.sv
// Free-running Fibonacci LFSR used as the lights-out delay source.
// Seeded with 1 on reset; a maximal-length tap set keeps it off zero.
module f1_lfsr
   import f1_pkg::*;
#(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] q
);

   localparam logic [7:0]       TAPS_ALL = lfsr_taps(WIDTH);
   localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

   logic fb;

   assign fb = ^(q & TAPS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= WIDTH'(1);
      end else begin
         q <= {q[WIDTH-2:0], fb};
      end
   end

endmodule

// File: rtl/f1_start_lights.sv
// F1 start-light sequencer: fill lights on ticks, hold for a random tick
// count, go dark, then time the driver's reaction. F1_FALSE_START_EN adds
// false-start detection during FILL/HOLD and the false_start output.
module f1_start_lights
   import f1_pkg::*;
#(
   parameter int NUM_LIGHTS  = 8,
   parameter int LFSR_WIDTH  = 7,
   parameter int REACT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   trigger,
   input  logic                   tick,
   input  logic                   react_btn,
   output logic [NUM_LIGHTS-1:0]  lights,
   output logic                   busy,
   output logic                   time_valid,
   output logic [REACT_WIDTH-1:0] react_time,
`ifdef F1_FALSE_START_EN
   output logic                   false_start,
`endif
   output f1_state_t              state
);

   localparam int                     FILL_W    = $clog2(NUM_LIGHTS + 1);
   localparam logic [FILL_W-1:0]      FILL_LAST = FILL_W'(NUM_LIGHTS - 1);
   localparam logic [REACT_WIDTH-1:0] REACT_MAX = '1;

   f1_state_t              next_state;
   logic [FILL_W-1:0]      fill_cnt;
   logic [LFSR_WIDTH-1:0]  delay_cnt;
   logic [LFSR_WIDTH-1:0]  lfsr_q;
   logic [REACT_WIDTH-1:0] react_cnt;

   logic start;
   logic fill_step;
   logic load_delay;
   logic delay_step;
   logic lights_out;
   logic react_step;
   logic capture;
   logic false_hit;

   f1_lfsr #(
      .WIDTH (LFSR_WIDTH)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A false-start press outranks a simultaneous tick in FILL/HOLD.
   always_comb begin
      next_state = state;
      start      = 1'b0;
      fill_step  = 1'b0;
      load_delay = 1'b0;
      delay_step = 1'b0;
      lights_out = 1'b0;
      react_step = 1'b0;
      capture    = 1'b0;
      false_hit  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (trigger) begin
               next_state = FILL;
               start      = 1'b1;
            end
         end
         FILL: begin
`ifdef F1_FALSE_START_EN
            if (react_btn) begin
               next_state = DONE;
               false_hit  = 1'b1;
            end else
`endif
            if (tick) begin
               fill_step = 1'b1;
               if (fill_cnt == FILL_LAST) begin
                  next_state = HOLD;
                  load_delay = 1'b1;
               end
            end
         end
         HOLD: begin
`ifdef F1_FALSE_START_EN
            if (react_btn) begin
               next_state = DONE;
               false_hit  = 1'b1;
            end else
`endif
            if (tick) begin
               if (delay_cnt == LFSR_WIDTH'(1)) begin
                  next_state = TIMING;
                  lights_out = 1'b1;
               end else begin
                  delay_step = 1'b1;
               end
            end
         end
         TIMING: begin
            if (react_btn) begin
               next_state = DONE;
               capture    = 1'b1;
            end else begin
               react_step = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // time_valid is a level flag: it rises with react_time on the capturing
   // edge and both hold until the next accepted trigger or reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_cnt   <= '0;
         delay_cnt  <= '0;
         react_cnt  <= '0;
         react_time <= '0;
         time_valid <= 1'b0;
      end else begin
         if (start) begin
            fill_cnt <= '0;
         end else if (fill_step) begin
            fill_cnt <= fill_cnt + FILL_W'(1);
         end

         if (load_delay) begin
            delay_cnt <= lfsr_q;
         end else if (delay_step) begin
            delay_cnt <= delay_cnt - LFSR_WIDTH'(1);
         end

         if (lights_out) begin
            react_cnt <= '0;
         end else if (react_step && (react_cnt != REACT_MAX)) begin
            react_cnt <= react_cnt + REACT_WIDTH'(1);
         end

         if (start) begin
            time_valid <= 1'b0;
         end else if (capture) begin
            time_valid <= 1'b1;
            react_time <= react_cnt;
         end
      end
   end

`ifdef F1_FALSE_START_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         false_start <= 1'b0;
      end else if (start) begin
         false_start <= 1'b0;
      end else if (false_hit) begin
         false_start <= 1'b1;
      end
   end
`endif

   always_comb begin
      lights = '0;
      if (state == HOLD) begin
         lights = '1;
      end else if (state == FILL) begin
         for (int i = 0; i < NUM_LIGHTS; i++) begin
            lights[i] = (FILL_W'(i) < fill_cnt);
         end
      end
   end

   assign busy = (state == FILL) || (state == HOLD) || (state == TIMING);

endmodule

// File: tb/tb_f1_start_lights.sv
// Bench for f1_start_lights: default-width instance plus a REACT_WIDTH=4
// instance sharing the same stimulus, checked against a rule-level model.
module tb_f1_start_lights;
   import f1_pkg::*;

   localparam int NL       = 8;
   localparam int LW       = 7;
   localparam int RW       = 16;
   localparam int TAP_MASK = (1 << 6) | (1 << 5);

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic trigger   = 1'b0;
   logic tick      = 1'b0;
   logic react_btn = 1'b0;

   logic [NL-1:0] lights, lights4;
   logic          busy, busy4;
   logic          time_valid, time_valid4;
   logic [RW-1:0] react_time;
   logic [3:0]    react_time4;
   f1_state_t     state, state4;
`ifdef F1_FALSE_START_EN
   logic          false_start, false_start4;
   localparam bit FS_EN = 1'b1;
`else
   localparam bit FS_EN = 1'b0;
`endif

   int checks    = 0;
   int failures  = 0;
   int lfsr_m    = 1;
   int edge_lfsr = 1;

   always #5 clk = ~clk;

   f1_start_lights #(
      .NUM_LIGHTS (NL),
      .LFSR_WIDTH (LW),
      .REACT_WIDTH(RW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .trigger    (trigger),
      .tick       (tick),
      .react_btn  (react_btn),
      .lights     (lights),
      .busy       (busy),
      .time_valid (time_valid),
      .react_time (react_time),
`ifdef F1_FALSE_START_EN
      .false_start(false_start),
`endif
      .state      (state)
   );

   f1_start_lights #(
      .NUM_LIGHTS (NL),
      .LFSR_WIDTH (LW),
      .REACT_WIDTH(4)
   ) dut4 (
      .clk        (clk),
      .rst        (rst),
      .trigger    (trigger),
      .tick       (tick),
      .react_btn  (react_btn),
      .lights     (lights4),
      .busy       (busy4),
      .time_valid (time_valid4),
      .react_time (react_time4),
`ifdef F1_FALSE_START_EN
      .false_start(false_start4),
`endif
      .state      (state4)
   );

   function automatic int lfsr_next(input int v);
      int fb;
      fb = $countones(v & TAP_MASK) & 1;
      return ((v << 1) | fb) & ((1 << LW) - 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; the model LFSR value seen at that edge is kept.
   task automatic cyc();
      @(posedge clk);
      edge_lfsr = lfsr_m;
      if (rst) lfsr_m = 1;
      else     lfsr_m = lfsr_next(lfsr_m);
      #1;
   endtask

   task automatic gap();
      int g;
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
         trigger   = 1'($urandom_range(0, 1));
         react_btn = FS_EN ? 1'b0 : 1'($urandom_range(0, 1));
         cyc();
         trigger   = 1'b0;
         react_btn = 1'b0;
      end
   endtask

   task automatic do_tick();
      tick      = 1'b1;
      react_btn = FS_EN ? 1'b0 : 1'($urandom_range(0, 1));
      cyc();
      tick      = 1'b0;
      react_btn = 1'b0;
   endtask

   task automatic run_round(input int n);
      int d;
      int exp_small;
      d = 0;
      exp_small = (n > 15) ? 15 : n;
      trigger = 1'b1;
      cyc();
      trigger = 1'b0;
      check("start_busy", busy, 1);
      check("start_state", state, FILL);
      check("start_valid", time_valid, 0);
      check("start_lights", lights, 0);
      for (int k = 1; k <= NL; k++) begin
         gap();
         do_tick();
         if (k == NL) d = edge_lfsr;
         check("fill_lights", lights, (1 << k) - 1);
      end
      check("hold_state", state, HOLD);
      check("hold_busy", busy, 1);
      for (int j = 1; j <= d; j++) begin
         gap();
         do_tick();
         check("hold_lights", lights, (j < d) ? 255 : 0);
      end
      check("out_state", state, TIMING);
      check("out_busy", busy, 1);
      for (int i = 0; i < n; i++) begin
         tick    = 1'($urandom_range(0, 1));
         trigger = 1'($urandom_range(0, 1));
         cyc();
         tick    = 1'b0;
         trigger = 1'b0;
      end
      react_btn = 1'b1;
      cyc();
      react_btn = 1'b0;
      check("react_time", react_time, n);
      check("react_time_w4", react_time4, exp_small);
      check("time_valid", time_valid, 1);
      check("time_valid_w4", time_valid4, 1);
      check("done_busy", busy, 0);
      check("done_state", state, DONE);
      check("done_lights", lights, 0);
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         check("done_tick_lights", lights, 0);
         check("done_hold_valid", time_valid, 1);
         check("done_hold_time", react_time, n);
      end
   endtask

   initial begin
      int d;
      int h;
      rst = 1'b1;
      cyc();
      cyc();
      check("rst_lights", lights, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", time_valid, 0);
      check("rst_time", react_time, 0);
      check("rst_state", state, IDLE);
`ifdef F1_FALSE_START_EN
      check("rst_false", false_start, 0);
`endif
      rst = 1'b0;

      tick = 1'b1;
      cyc();
      cyc();
      tick = 1'b0;
      check("idle_tick_lights", lights, 0);
      check("idle_tick_state", state, IDLE);

      run_round(37);
      run_round(0);
      run_round(30);
      run_round($urandom_range(1, 300));

      // Abort in HOLD with an asynchronous reset between clock edges.
      trigger = 1'b1;
      cyc();
      trigger = 1'b0;
      d = 0;
      for (int k = 1; k <= NL; k++) begin
         do_tick();
         if (k == NL) d = edge_lfsr;
      end
      h = (d > 2) ? 2 : d - 1;
      for (int j = 0; j < h; j++) do_tick();
      check("abort_pre_state", state, HOLD);
      #2 rst = 1'b1;
      #1;
      lfsr_m = 1;
      check("abort_lights", lights, 0);
      check("abort_busy", busy, 0);
      check("abort_valid", time_valid, 0);
      check("abort_time", react_time, 0);
      check("abort_state", state, IDLE);
      cyc();
      cyc();
      rst = 1'b0;
      run_round($urandom_range(1, 100));

`ifdef F1_FALSE_START_EN
      trigger = 1'b1;
      cyc();
      trigger = 1'b0;
      for (int k = 0; k < 3; k++) do_tick();
      check("fs_pre_lights", lights, 7);
      react_btn = 1'b1;
      cyc();
      react_btn = 1'b0;
      check("fs_lights", lights, 0);
      check("fs_flag", false_start, 1);
      check("fs_flag_w4", false_start4, 1);
      check("fs_valid", time_valid, 0);
      check("fs_state", state, DONE);
      trigger = 1'b1;
      cyc();
      trigger = 1'b0;
      check("fs_clear", false_start, 0);
      check("fs_restart_busy", busy, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
